// File: rtl/window_row_feeder_pkg.sv
// window_row_feeder_pkg: shared pixel type, chunk geometry and feeder FSM states.
package window_row_feeder_pkg;
  typedef logic signed [7:0] int8_t;
  localparam int PIX_PER_CHUNK = 4;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} feed_state_t;
endpackage

// File: rtl/window_row_feeder_fifo2.sv
// fifo2: 2-entry FIFO carrying a data word plus a one-bit tag.
module fifo2
  import window_row_feeder_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         push_tag,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         head_tag,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);
  logic [W:0] ent0, ent1;
  logic wp, rp, do_push, do_pop;
  always_comb begin
    full = count == 2'd2;
    empty = count == 2'd0;
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    {head_tag, head_data} = rp ? ent1 : ent0;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent0 <= '0;
      ent1 <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      count <= 2'd0;
    end else begin
      if (do_push) begin
        if (wp) ent1 <= {push_tag, push_data};
        else ent0 <= {push_tag, push_data};
        wp <= !wp;
      end
      if (do_pop) rp <= !rp;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end
endmodule

// File: rtl/window_row_feeder.sv
// window_row_feeder: streams an int8 image column-strip by column-strip from SRAM.
// Define WINDOW_FEED_ZERO_PAD_EN to add a zero row above and below every strip.
module window_row_feeder
  import window_row_feeder_pkg::*;
#(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              stall,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rd_data,
  output logic              valid_out,
  output logic [31:0]       pixels_out_chunk_bus,
  output logic              strip_first,
  output logic              busy,
  output logic              done
);
  localparam int WPR = IMG_W / PIX_PER_CHUNK;
`ifdef WINDOW_FEED_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif
  localparam int ROWS = IMG_H + (PAD ? 2 : 0);
  localparam int CW = WPR > 1 ? $clog2(WPR) : 1;
  localparam int RW = $clog2(ROWS);

  feed_state_t state, state_nx;
  logic [CW-1:0] cx;
  logic [RW-1:0] row;
  logic [ADDR_W-1:0] addr, strip_addr;
  logic inflight, inflight_pad, inflight_tag;
  logic issue, pad_row, last_row, last, pop, drained;
  logic full, empty, head_tag;
  logic [1:0] count;

  fifo2 #(.W(32)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight),
    .push_data (inflight_pad ? 32'd0 : mem_rd_data),
    .push_tag  (inflight_tag),
    .pop       (pop),
    .head_data (pixels_out_chunk_bus),
    .head_tag  (head_tag),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= state_nx;
  end

  // Drain ends as the last entry leaves, so done follows the final word by one cycle.
  always_comb begin
    drained = !inflight && (empty || (count == 2'd1 && pop));
    state_nx = state == IDLE ? (start ? RUN : IDLE) :
               state == RUN ? (issue && last ? DRAIN : RUN) :
               state == DRAIN ? (drained ? DONE : DRAIN) : IDLE;
  end

  always_comb begin
    last_row = row == RW'(ROWS - 1);
    pad_row = PAD && (row == '0 || last_row);
    last = last_row && cx == CW'(WPR - 1);
    pop = !empty && !stall;
    issue = state == RUN && ({1'b0, count} + {2'b0, inflight} < 3'd2 + {2'b0, pop});
    mem_rd_en = issue && !pad_row;
    mem_addr = addr;
    valid_out = pop;
    strip_first = pop && head_tag;
    busy = state != IDLE;
    done = state == DONE;
  end

  // Addresses advance by adding WPR per row and 1 per strip; no multiplier.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cx <= '0;
      row <= '0;
      addr <= '0;
      strip_addr <= '0;
      inflight <= 1'b0;
      inflight_pad <= 1'b0;
      inflight_tag <= 1'b0;
    end else begin
      inflight <= issue;
      inflight_pad <= pad_row;
      inflight_tag <= row == '0;
      if (state == IDLE && start) begin
        addr <= base_addr;
        strip_addr <= base_addr;
        cx <= '0;
        row <= '0;
      end else if (issue) begin
        if (last_row) begin
          row <= '0;
          cx <= cx + 1'b1;
          strip_addr <= strip_addr + 1'b1;
          addr <= strip_addr + 1'b1;
        end else begin
          row <= row + 1'b1;
          if (!pad_row) addr <= addr + ADDR_W'(WPR);
        end
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset) !(inflight && full && !pop));
endmodule
